pll_reconfig_seq: RTL and testbench

//  Generalised PLL reconfiguration sequencer; drives the Avalon-MM port of pll_cfg from a per-mode register table.
//  A change on mode_in (e.g. NTSC/PAL) or a reload pulse runs this write sequence:

---
 rtl/pll_reconfig_seq.sv | 187 ++++++++++++++++++
 tb/tb_pll_reconfig_seq.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: per-mode table writes to pll_cfg, then lock wait; holds tv_reset meanwhile.
// Writes leave combinationally in any cycle with mgmt_waitrequest low; while it is high the sequencer stalls in place.
module pll_reconfig_seq #(
  parameter int NUM_MODES = 2,
  parameter int MODE_W = 1,
  parameter int NUM_WRITES = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter logic [NUM_WRITES*ADDR_W-1:0] TBL_ADDR = {6'd7, 6'd5, 6'd4, 6'd3},
  parameter logic [NUM_MODES*NUM_WRITES*DATA_W-1:0] TBL_DATA = '0,
  parameter int SYNC_STAGES = 2,
  parameter int UNLOCK_WAIT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter bit PROGRAM_ON_RESET = 1'b0
) (
  input  logic              mgmt_clk,
  input  logic              mgmt_reset,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              reload,
  input  logic              pll_locked,
  input  logic              mgmt_waitrequest,
  output logic              mgmt_write,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic [DATA_W-1:0] mgmt_writedata,
  output logic              tv_reset,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [MODE_W-1:0] cur_mode
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > UNLOCK_WAIT) ? LOCK_TIMEOUT : UNLOCK_WAIT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int K_W = (NUM_WRITES > 1) ? $clog2(NUM_WRITES) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [2:0] {IDLE, WMODE, PROG, START, WAIT_UNLOCK, WAIT_LOCK, DONE} state_t;

  state_t             state, state_n;
  logic [K_W-1:0]     k, k_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [MODE_W-1:0]  cur_mode_n;
  logic               tv_reset_n, timeout_n, armed, armed_n;
  logic [ADDR_W-1:0]  last_addr, wr_addr;
  logic [DATA_W-1:0]  last_data, wr_data;
  logic [FILL_W-1:0]  fill;
  logic               filled, wr_fire, mode_valid, change, locked_s;
  logic [MODE_W-1:0]  mode_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [MODE_W-1:0]  sync_mode;

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) mode_sync[i] <= '0;
      lock_sync <= '0;
    end else begin
      mode_sync[0] <= mode_in;
      for (int i = 1; i < SYNC_STAGES; i++) mode_sync[i] <= mode_sync[i-1];
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign sync_mode  = mode_sync[SYNC_STAGES-1];
  assign locked_s   = lock_sync[SYNC_STAGES-1];
  assign mode_valid = int'(sync_mode) < NUM_MODES;
  assign change     = mode_valid && (sync_mode != cur_mode);
  // the power-on start waits until the synchronisers hold real samples
  assign filled     = (fill == FILL_W'(SYNC_STAGES));

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (state == PROG) begin
      wr_addr = TBL_ADDR[int'(k)*ADDR_W +: ADDR_W];
      wr_data = TBL_DATA[(int'(cur_mode)*NUM_WRITES + int'(k))*DATA_W +: DATA_W];
    end else if (state == START) begin
      wr_addr = ADDR_W'(2);
    end
  end

  assign wr_fire        = (state inside {WMODE, PROG, START}) && !mgmt_waitrequest;
  assign mgmt_write     = wr_fire;
  assign mgmt_address   = wr_fire ? wr_addr : last_addr;
  assign mgmt_writedata = wr_fire ? wr_data : last_data;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

  always_comb begin
    state_n    = state;
    k_n        = k;
    cnt_n      = cnt;
    cur_mode_n = cur_mode;
    tv_reset_n = tv_reset;
    timeout_n  = timeout_err;
    armed_n    = armed;
    case (state)
      IDLE: begin
        if (change || reload || (armed && filled)) begin
          state_n    = WMODE;
          k_n        = '0;
          armed_n    = 1'b0;
          tv_reset_n = 1'b1;
          timeout_n  = 1'b0;
          if (mode_valid) cur_mode_n = sync_mode;
        end
      end
      WMODE, PROG, START: begin
        if (wr_fire) begin
          if (state == WMODE) begin
            state_n = PROG;
            k_n     = '0;
          end else if (state == PROG) begin
            if (k == K_W'(NUM_WRITES-1)) state_n = START;
            else k_n = k + 1'b1;
          end else begin
            state_n = WAIT_UNLOCK;
            cnt_n   = '0;
          end
          // a mode change lets the in-flight write land, then restarts the table
          if (change) begin
            state_n    = WMODE;
            k_n        = '0;
            cur_mode_n = sync_mode;
          end
        end
      end
      WAIT_UNLOCK, WAIT_LOCK: begin
        if (change) begin
          state_n    = WMODE;
          k_n        = '0;
          cnt_n      = '0;
          cur_mode_n = sync_mode;
        end else if (state == WAIT_UNLOCK) begin
          if (!locked_s || cnt == CNT_W'(UNLOCK_WAIT-1)) begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt != '1) begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          if (locked_s) begin
            state_n = DONE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT-1)) begin
            state_n   = DONE;
            timeout_n = 1'b1;
          end else if (cnt != '1) begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        tv_reset_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      state       <= IDLE;
      k           <= '0;
      cnt         <= '0;
      cur_mode    <= '0;
      tv_reset    <= PROGRAM_ON_RESET;
      timeout_err <= 1'b0;
      armed       <= PROGRAM_ON_RESET;
      last_addr   <= '0;
      last_data   <= '0;
      fill        <= '0;
    end else begin
      state       <= state_n;
      k           <= k_n;
      cnt         <= cnt_n;
      cur_mode    <= cur_mode_n;
      tv_reset    <= tv_reset_n;
      timeout_err <= timeout_n;
      armed       <= armed_n;
      if (!filled) fill <= fill + 1'b1;
      if (wr_fire) begin
        last_addr <= wr_addr;
        last_data <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: a PLL/lock and waitrequest model drives the inputs,
// each scenario task compares observed writes and flags against hand-derived values.
module tb_pll_reconfig_seq;
  localparam logic [255:0] TBL = {32'hC0DE_0103, 32'hC0DE_0102, 32'hC0DE_0101, 32'hC0DE_0100,
                                  32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

  logic CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  logic rst1, rst2, reload, pll_locked, wreq;
  logic [1:0] mode_in;
  logic wr1, tv1, busy1, done1, to1, wr2, tv2, busy2, done2, to2;
  logic [5:0] addr1, addr2;
  logic [31:0] data1, data2;
  logic [1:0] cm1, cm2;

  pll_reconfig_seq #(.NUM_MODES(2), .MODE_W(2), .NUM_WRITES(4), .ADDR_W(6), .DATA_W(32),
    .TBL_ADDR({6'd7, 6'd5, 6'd4, 6'd3}), .TBL_DATA(TBL), .SYNC_STAGES(2), .UNLOCK_WAIT(64),
    .LOCK_TIMEOUT(100), .PROGRAM_ON_RESET(1'b0)) dut (
    .mgmt_clk(CLK_50M), .mgmt_reset(rst1), .mode_in(mode_in), .reload(reload),
    .pll_locked(pll_locked), .mgmt_waitrequest(wreq), .mgmt_write(wr1), .mgmt_address(addr1),
    .mgmt_writedata(data1), .tv_reset(tv1), .busy(busy1), .done(done1), .timeout_err(to1),
    .cur_mode(cm1));

  pll_reconfig_seq #(.NUM_MODES(2), .MODE_W(2), .NUM_WRITES(4), .ADDR_W(6), .DATA_W(32),
    .TBL_ADDR({6'd7, 6'd5, 6'd4, 6'd3}), .TBL_DATA(TBL), .SYNC_STAGES(2), .UNLOCK_WAIT(64),
    .LOCK_TIMEOUT(100), .PROGRAM_ON_RESET(1'b1)) dut_por (
    .mgmt_clk(CLK_50M), .mgmt_reset(rst2), .mode_in(mode_in), .reload(reload),
    .pll_locked(pll_locked), .mgmt_waitrequest(wreq), .mgmt_write(wr2), .mgmt_address(addr2),
    .mgmt_writedata(data2), .tv_reset(tv2), .busy(busy2), .done(done2), .timeout_err(to2),
    .cur_mode(cm2));

  int errors = 0;
  int checks = 0;

  logic [5:0]  obs_addr [$];
  logic [31:0] obs_data [$];
  int          obs_cyc  [$];
  int cyc = 0;
  int done_cnt, done_cyc, tv_bad, strobe_bad;
  logic done_to;

  int stall_len = 0;
  bit force_wait = 1'b0;
  int lock_mode = 0;   // 0: drop 3 cycles after START, back 20 later; 1: held high; 2: held low
  int stall_cnt = 0;
  int lk_t = 0;

  // PLL and pll_cfg behaviour: observe at negedge, drive just after the next posedge
  initial begin
    wreq = 1'b0;
    pll_locked = 1'b1;
    forever begin
      @(negedge CLK_50M);
      if (wr1 && stall_len > 0) stall_cnt = stall_len;
      if (wr1 && addr1 == 6'd2) lk_t = 1;
      else if (lk_t > 0) lk_t++;
      if (lk_t >= 24) lk_t = 0;
      @(posedge CLK_50M);
      #1;
      if (stall_cnt > 0) begin
        wreq = 1'b1;
        stall_cnt--;
      end else begin
        wreq = force_wait;
      end
      case (lock_mode)
        1: pll_locked = 1'b1;
        2: pll_locked = 1'b0;
        default: pll_locked = !(lk_t >= 4);
      endcase
    end
  end

  function automatic logic [5:0] exp_addr(input int j);
    case (j)
      0: return 6'd0;
      1: return 6'd3;
      2: return 6'd4;
      3: return 6'd5;
      4: return 6'd7;
      default: return 6'd2;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int m, input int j);
    if (j >= 1 && j <= 4) return 32'hC0DE_0000 + 32'(m * 256 + (j - 1));
    return 32'h0;
  endfunction

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    obs_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    done_to = 1'b0;
    tv_bad = 0;
    strobe_bad = 0;
  endtask

  task automatic step();
    @(negedge CLK_50M);
    cyc++;
    if (wr1) begin
      obs_addr.push_back(addr1);
      obs_data.push_back(data1);
      obs_cyc.push_back(cyc);
    end
    if (done1) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc = cyc;
        done_to = to1;
      end
    end
    if (busy1 && !tv1) tv_bad++;
    if (wr1 && wreq) strobe_bad++;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst2 = 1'b1; mode_in = 2'd0; reload = 1'b0;
    repeat (3) @(negedge CLK_50M);
    checks++;
    if ({wr1, busy1, tv1, done1, to1} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, expected 00000", {wr1, busy1, tv1, done1, to1});
    end
    rst1 = 1'b0;
    step();
    checks++;
    if ({cm1, addr1, data1} !== 40'h0) begin
      errors++; $display("FAIL reset_bus: mode=%0d addr=%0d data=%h, expected all 0", cm1, addr1, data1);
    end
    checks++;
    if ({tv2, busy2, wr2} !== 3'b100) begin
      errors++; $display("FAIL reset_por_tv: tv/busy/write=%b, expected 100", {tv2, busy2, wr2});
    end
    clear_obs();
    repeat (10) step();
    checks++;
    if (obs_addr.size() != 0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_idle: writes=%0d busy=%b, expected 0 and 0", obs_addr.size(), busy1);
    end
  endtask

  task automatic test_mode_change();
    clear_obs();
    mode_in = 2'd1;
    run_until_done(300);
    checks++;
    if (obs_addr.size() != 6) begin
      errors++; $display("FAIL t1_count: %0d writes, expected 6", obs_addr.size());
    end
    for (int j = 0; j < 6; j++) begin
      logic [5:0] a; logic [31:0] d;
      a = (j < obs_addr.size()) ? obs_addr[j] : 6'bx;
      d = (j < obs_data.size()) ? obs_data[j] : 32'bx;
      checks++;
      if (a !== exp_addr(j) || d !== exp_data(1, j)) begin
        errors++; $display("FAIL t1_write%0d: addr=%0d data=%h, expected addr=%0d data=%h", j, a, d, exp_addr(j), exp_data(1, j));
      end
    end
    checks++;
    if (obs_cyc.size() != 6 || obs_cyc[5] - obs_cyc[0] != 5) begin
      errors++; $display("FAIL t1_back_to_back: writes not on 6 consecutive cycles");
    end
    checks++;
    if (obs_cyc.size() != 6 || done_cyc - obs_cyc[5] != 27) begin
      errors++; $display("FAIL t1_lock_wait: done %0d cycles after start write, expected 27", done_cyc - (obs_cyc.size() == 6 ? obs_cyc[5] : 0));
    end
    checks++;
    if (done_cnt != 1 || tv_bad != 0 || done_to !== 1'b0) begin
      errors++; $display("FAIL t1_flags: done=%0d tv_low_busy=%0d timeout=%b, expected 1 0 0", done_cnt, tv_bad, done_to);
    end
    checks++;
    if (cm1 !== 2'd1 || tv1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL t1_end: cur_mode=%0d tv_reset=%b busy=%b, expected 1 0 0", cm1, tv1, busy1);
    end
  endtask

  task automatic test_waitrequest();
    clear_obs();
    stall_len = 5;
    mode_in = 2'd0;
    run_until_done(400);
    stall_len = 0;
    checks++;
    if (obs_addr.size() != 6) begin
      errors++; $display("FAIL t2_count: %0d writes, expected 6", obs_addr.size());
    end
    for (int j = 0; j < 6; j++) begin
      logic [5:0] a; logic [31:0] d;
      a = (j < obs_addr.size()) ? obs_addr[j] : 6'bx;
      d = (j < obs_data.size()) ? obs_data[j] : 32'bx;
      checks++;
      if (a !== exp_addr(j) || d !== exp_data(0, j)) begin
        errors++; $display("FAIL t2_write%0d: addr=%0d data=%h, expected addr=%0d data=%h", j, a, d, exp_addr(j), exp_data(0, j));
      end
    end
    for (int j = 1; j < obs_cyc.size(); j++) begin
      checks++;
      if (obs_cyc[j] - obs_cyc[j-1] != 6) begin
        errors++; $display("FAIL t2_gap%0d: %0d cycles between writes, expected 6", j, obs_cyc[j] - obs_cyc[j-1]);
      end
    end
    checks++;
    if (strobe_bad != 0 || done_cnt != 1 || cm1 !== 2'd0) begin
      errors++; $display("FAIL t2_flags: strobes_in_wait=%0d done=%0d cur_mode=%0d, expected 0 1 0", strobe_bad, done_cnt, cm1);
    end
    repeat (10) step();
  endtask

  task automatic test_restart();
    int n = 0;
    clear_obs();
    mode_in = 2'd1;
    while (obs_addr.size() < 3 && n < 50) begin
      step();
      n++;
    end
    force_wait = 1'b1;
    mode_in = 2'd0;
    repeat (6) step();
    checks++;
    if (obs_addr.size() != 3 || cm1 !== 2'd1 || busy1 !== 1'b1) begin
      errors++; $display("FAIL t3_hold: writes=%0d cur_mode=%0d busy=%b, expected 3 1 1", obs_addr.size(), cm1, busy1);
    end
    force_wait = 1'b0;
    run_until_done(300);
    checks++;
    if (obs_addr.size() != 10) begin
      errors++; $display("FAIL t3_count: %0d writes, expected 10", obs_addr.size());
    end
    for (int j = 0; j < 10; j++) begin
      logic [5:0] a, ea; logic [31:0] d, ed;
      a = (j < obs_addr.size()) ? obs_addr[j] : 6'bx;
      d = (j < obs_data.size()) ? obs_data[j] : 32'bx;
      ea = (j < 4) ? exp_addr(j) : exp_addr(j - 4);
      ed = (j < 4) ? exp_data(1, j) : exp_data(0, j - 4);
      checks++;
      if (a !== ea || d !== ed) begin
        errors++; $display("FAIL t3_write%0d: addr=%0d data=%h, expected addr=%0d data=%h", j, a, d, ea, ed);
      end
    end
    checks++;
    if (done_cnt != 1 || tv_bad != 0 || cm1 !== 2'd0) begin
      errors++; $display("FAIL t3_flags: done=%0d tv_low_busy=%0d cur_mode=%0d, expected 1 0 0", done_cnt, tv_bad, cm1);
    end
    repeat (10) step();
  endtask

  task automatic test_lock();
    lock_mode = 1;
    repeat (4) step();
    clear_obs();
    pulse_reload();
    run_until_done(300);
    checks++;
    if (obs_cyc.size() != 6 || done_cyc - obs_cyc[5] != 66 || done_to !== 1'b0) begin
      errors++; $display("FAIL t4_unlock_wait: writes=%0d done_delay=%0d timeout=%b, expected 6 66 0", obs_cyc.size(), done_cyc - (obs_cyc.size() == 6 ? obs_cyc[5] : 0), done_to);
    end
    lock_mode = 2;
    repeat (5) step();
    clear_obs();
    pulse_reload();
    run_until_done(400);
    checks++;
    if (obs_cyc.size() != 6 || done_cyc - obs_cyc[5] != 102) begin
      errors++; $display("FAIL t4_timeout_delay: done %0d cycles after start write, expected 102", done_cyc - (obs_cyc.size() == 6 ? obs_cyc[5] : 0));
    end
    checks++;
    if (done_to !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL t4_timeout_flag: timeout at done=%b done_count=%0d, expected 1 1", done_to, done_cnt);
    end
    repeat (5) step();
    checks++;
    if (to1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL t4_sticky: timeout=%b busy=%b, expected 1 0", to1, busy1);
    end
    lock_mode = 0;
    repeat (5) step();
  endtask

  task automatic test_reload();
    int n = 0;
    int busy_seen = 0;
    clear_obs();
    pulse_reload();
    while (obs_addr.size() < 1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (to1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL t5_start: timeout=%b busy=%b, expected 0 1", to1, busy1);
    end
    pulse_reload();
    run_until_done(300);
    repeat (60) step();
    checks++;
    if (obs_addr.size() != 6 || done_cnt != 1) begin
      errors++; $display("FAIL t5_reload_busy: writes=%0d done=%0d, expected 6 1", obs_addr.size(), done_cnt);
    end
    for (int j = 0; j < 6; j++) begin
      logic [5:0] a; logic [31:0] d;
      a = (j < obs_addr.size()) ? obs_addr[j] : 6'bx;
      d = (j < obs_data.size()) ? obs_data[j] : 32'bx;
      checks++;
      if (a !== exp_addr(j) || d !== exp_data(0, j)) begin
        errors++; $display("FAIL t5_write%0d: addr=%0d data=%h, expected addr=%0d data=%h", j, a, d, exp_addr(j), exp_data(0, j));
      end
    end
    mode_in = 2'd3;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy1) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || cm1 !== 2'd0) begin
      errors++; $display("FAIL t5_invalid_mode: busy_cycles=%0d cur_mode=%0d, expected 0 0", busy_seen, cm1);
    end
    mode_in = 2'd0;
    repeat (5) step();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int busy_seen = 0;
    bit found = 1'b0;
    clear_obs();
    mode_in = 2'd1;
    while (obs_addr.size() < 4 && n < 50) begin
      step();
      n++;
    end
    #1 rst1 = 1'b1;
    #1;
    checks++;
    if (obs_addr.size() != 4 || {wr1, tv1, busy1} !== 3'b000) begin
      errors++; $display("FAIL t6_async_reset: writes=%0d write/tv/busy=%b, expected 4 000", obs_addr.size(), {wr1, tv1, busy1});
    end
    mode_in = 2'd0;
    repeat (3) step();
    rst1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy1) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || cm1 !== 2'd0) begin
      errors++; $display("FAIL t6_no_rerun: busy_cycles=%0d cur_mode=%0d, expected 0 0", busy_seen, cm1);
    end
    rst2 = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK_50M);
      if (wr2 && addr2 == 6'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL t6_por_run: no PROG k=2 write within 40 cycles, expected one");
    end
    #1 rst2 = 1'b1;
    #1;
    checks++;
    if ({wr2, busy2, tv2} !== 3'b001) begin
      errors++; $display("FAIL t6_por_reset: write/busy/tv=%b, expected 001", {wr2, busy2, tv2});
    end
    repeat (2) @(negedge CLK_50M);
    rst2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK_50M);
      if (wr2) found = 1'b1;
    end
    checks++;
    if (!found || addr2 !== 6'd0 || data2 !== 32'h0 || cm2 !== 2'd0) begin
      errors++; $display("FAIL t6_restart_wmode: seen=%b addr=%0d data=%h mode=%0d, expected 1 0 0 0", found, addr2, data2, cm2);
    end
    @(negedge CLK_50M);
    checks++;
    if (wr2 !== 1'b1 || addr2 !== 6'd3 || data2 !== exp_data(0, 1)) begin
      errors++; $display("FAIL t6_restart_prog0: write=%b addr=%0d data=%h, expected 1 3 %h", wr2, addr2, data2, exp_data(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_mode_change();
    test_waitrequest();
    test_restart();
    test_lock();
    test_reload();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
